// File: rtl/ram_rtl_pkg.sv
// Shared defaults and types for the RAM responder: FSM states and the
// read-pipeline entry carried from capture to the rd_* outputs.
package ram_rtl_pkg;

   localparam int unsigned RAM_ADDR_WIDTH = 4;
   localparam int unsigned RAM_DATA_WIDTH = 8;
   localparam int unsigned RAM_DEPTH      = 16;
   localparam int unsigned RAM_RD_LAT     = 2;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } ram_state_e;

   typedef struct packed {
      logic                      valid;
      logic                      err;
      logic [RAM_DATA_WIDTH-1:0] data;
   } rd_entry_t;

endpackage

// File: rtl/ram_rd_pipe.sv
// Fixed-latency read return pipeline. Valid/err shift every cycle; data only
// advances with a valid entry, so the last stage holds the previous read data.
module ram_rd_pipe
   import ram_rtl_pkg::*;
#(
   parameter int unsigned RD_LAT  = RAM_RD_LAT,
   parameter type         T_ENTRY = rd_entry_t
) (
   input  logic   clk,
   input  logic   rst_n,
   input  T_ENTRY i_entry,
   output T_ENTRY o_entry
);

   T_ENTRY r_stage [RD_LAT];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0].valid <= i_entry.valid;
         r_stage[0].err   <= i_entry.err;
         if (i_entry.valid) begin
            r_stage[0].data <= i_entry.data;
         end
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            r_stage[i].valid <= r_stage[i-1].valid;
            r_stage[i].err   <= r_stage[i-1].err;
            if (r_stage[i-1].valid) begin
               r_stage[i].data <= r_stage[i-1].data;
            end
         end
      end
   end

   assign o_entry = r_stage[RD_LAT-1];

endmodule

// File: rtl/ram_responder.sv
// Memory end of the RAM read/write interface: clears the array after reset,
// then serves one write and one fixed-latency read per cycle.
module ram_responder
   import ram_rtl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH,
   parameter int unsigned DEPTH      = RAM_DEPTH,
   parameter int unsigned RD_LAT     = RAM_RD_LAT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_err,
   output logic                  init_done
);

   // Same layout as rd_entry_t, sized by this instance's DATA_WIDTH.
   typedef struct packed {
      logic                  valid;
      logic                  err;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(DEPTH - 1);

   ram_state_e            r_state;
   ram_state_e            w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_clr_cnt;
   logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic   w_wr_in_range;
   logic   w_rd_in_range;
   logic   w_wr_ok;
   logic   w_rd_ok;
   entry_t w_entry;
   entry_t w_out;

   generate
      if (DEPTH < (2 ** ADDR_WIDTH)) begin : g_partial
         assign w_wr_in_range = ({1'b0, wr_addr} < (ADDR_WIDTH + 1)'(DEPTH));
         assign w_rd_in_range = ({1'b0, rd_addr} < (ADDR_WIDTH + 1)'(DEPTH));
      end else begin : g_full
         assign w_wr_in_range = 1'b1;
         assign w_rd_in_range = 1'b1;
      end
   endgenerate

   assign w_wr_ok = (r_state == RUN) && wr_en && w_wr_in_range;
   assign w_rd_ok = (r_state == RUN) && rd_en;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= INIT;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      case (r_state)
         INIT: begin
            w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            if (r_clr_cnt == LP_LAST) begin
               w_state_nxt = RUN;
            end
         end
         RUN:     w_state_nxt = RUN;
         default: w_state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (r_state == INIT) begin
            r_mem[r_clr_cnt] <= '0;
         end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
         end
      end
   end

   // Write-first bypass: a same-cycle in-range write to the read address wins.
   always_comb begin
      w_entry       = '0;
      w_entry.valid = w_rd_ok;
      w_entry.err   = w_rd_ok && !w_rd_in_range;
      if (w_rd_ok && w_rd_in_range) begin
         if (w_wr_ok && (wr_addr == rd_addr)) begin
            w_entry.data = wr_data;
         end else begin
            w_entry.data = r_mem[rd_addr];
         end
      end
   end

   ram_rd_pipe #(
      .RD_LAT  (RD_LAT),
      .T_ENTRY (entry_t)
   ) u_rd_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_entry (w_entry),
      .o_entry (w_out)
   );

   assign rd_data   = w_out.data;
   assign rd_valid  = w_out.valid;
   assign rd_err    = w_out.valid && w_out.err;
   assign init_done = (r_state == RUN);

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: a DEPTH=16 and a DEPTH=12 instance share
// one stimulus stream; each scenario task checks its own expected values.
module tb_ram_responder;

   logic       clk;
   logic       rst_n;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [3:0] rd_addr;

   logic [7:0] a_rd_data;
   logic       a_rd_valid;
   logic       a_rd_err;
   logic       a_init_done;
   logic [7:0] b_rd_data;
   logic       b_rd_valid;
   logic       b_rd_err;
   logic       b_init_done;

   int n_checks;
   int n_pass;

   ram_responder #(
      .ADDR_WIDTH (4),
      .DATA_WIDTH (8),
      .DEPTH      (16),
      .RD_LAT     (2)
   ) u_dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (a_rd_data),
      .rd_valid  (a_rd_valid),
      .rd_err    (a_rd_err),
      .init_done (a_init_done)
   );

   ram_responder #(
      .ADDR_WIDTH (4),
      .DATA_WIDTH (8),
      .DEPTH      (12),
      .RD_LAT     (2)
   ) u_dut12 (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (b_rd_data),
      .rd_valid  (b_rd_valid),
      .rd_err    (b_rd_err),
      .init_done (b_init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_en   = 1'b0;
      rd_addr = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({a_rd_valid, a_rd_err, a_init_done, a_rd_data} !== 11'h000) begin
         $display("FAIL reset_outputs: got v=%b e=%b d=%b data=%h, want all 0",
                  a_rd_valid, a_rd_err, a_init_done, a_rd_data);
      end else n_pass++;
      rst_n = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 11) begin
            n_checks++;
            if (b_init_done !== 1'b0) $display("FAIL init12_early: got %b want 0", b_init_done);
            else n_pass++;
         end
         if (i == 12) begin
            n_checks++;
            if (b_init_done !== 1'b1) $display("FAIL init12_rise: got %b want 1", b_init_done);
            else n_pass++;
         end
         if (i == 15) begin
            n_checks++;
            if (a_init_done !== 1'b0) $display("FAIL init16_early: got %b want 0", a_init_done);
            else n_pass++;
         end
      end
      n_checks++;
      if (a_init_done !== 1'b1) $display("FAIL init16_rise: got %b want 1", a_init_done);
      else n_pass++;
   endtask

   task automatic test_idle_read();
      rd_en   = 1'b1;
      rd_addr = 4'd5;
      tick();
      idle_inputs();
      n_checks++;
      if (a_rd_valid !== 1'b0) $display("FAIL idle_read_early: valid got %b want 0", a_rd_valid);
      else n_pass++;
      tick();
      n_checks++;
      if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h00 || a_rd_err !== 1'b0) begin
         $display("FAIL idle_read: got v=%b d=%h e=%b want v=1 d=00 e=0",
                  a_rd_valid, a_rd_data, a_rd_err);
      end else n_pass++;
   endtask

   task automatic test_write_read();
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
      tick();
      idle_inputs();
      rd_en = 1'b1; rd_addr = 4'd3;
      tick();
      idle_inputs();
      n_checks++;
      if (a_rd_valid !== 1'b0) $display("FAIL wr_rd_early: valid got %b want 0", a_rd_valid);
      else n_pass++;
      tick();
      n_checks++;
      if (a_rd_valid !== 1'b1 || a_rd_data !== 8'hA5) begin
         $display("FAIL wr_rd_data: got v=%b d=%h want v=1 d=a5", a_rd_valid, a_rd_data);
      end else n_pass++;
      tick();
      n_checks++;
      if (a_rd_valid !== 1'b0 || a_rd_data !== 8'hA5 || a_rd_err !== 1'b0) begin
         $display("FAIL wr_rd_hold: got v=%b d=%h e=%b want v=0 d=a5 e=0",
                  a_rd_valid, a_rd_data, a_rd_err);
      end else n_pass++;
   endtask

   task automatic test_collision();
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h11;
      tick();
      rd_en = 1'b1; rd_addr = 4'd7; wr_data = 8'h3C;
      tick();
      rd_en = 1'b0; wr_data = 8'h99;
      tick();
      idle_inputs();
      n_checks++;
      if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h3C) begin
         $display("FAIL collision: got v=%b d=%h want v=1 d=3c", a_rd_valid, a_rd_data);
      end else n_pass++;
      rd_en = 1'b1; rd_addr = 4'd7;
      tick();
      idle_inputs();
      tick();
      n_checks++;
      if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h99) begin
         $display("FAIL collision_later_wr: got v=%b d=%h want v=1 d=99", a_rd_valid, a_rd_data);
      end else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'(i * 3 + 1);
         tick();
      end
      idle_inputs();
      for (int i = 0; i <= 17; i++) begin
         if (i < 16) begin
            rd_en = 1'b1; rd_addr = 4'(i);
         end else begin
            rd_en = 1'b0;
         end
         tick();
         if (i >= 1 && i <= 16) begin
            exp = 8'((i - 1) * 3 + 1);
            n_checks++;
            if (a_rd_valid !== 1'b1 || a_rd_data !== exp) begin
               $display("FAIL b2b_%0d: got v=%b d=%h want v=1 d=%h", i - 1, a_rd_valid, a_rd_data, exp);
            end else n_pass++;
         end
      end
      idle_inputs();
      n_checks++;
      if (a_rd_valid !== 1'b0) $display("FAIL b2b_end: valid got %b want 0", a_rd_valid);
      else n_pass++;
   endtask

   task automatic test_out_of_range();
      wr_en = 1'b1; wr_addr = 4'd13; wr_data = 8'hFF;
      tick();
      idle_inputs();
      rd_en = 1'b1; rd_addr = 4'd13;
      tick();
      rd_addr = 4'd11;
      tick();
      idle_inputs();
      n_checks++;
      if (b_rd_valid !== 1'b1 || b_rd_data !== 8'h00 || b_rd_err !== 1'b1) begin
         $display("FAIL oor12: got v=%b d=%h e=%b want v=1 d=00 e=1", b_rd_valid, b_rd_data, b_rd_err);
      end else n_pass++;
      n_checks++;
      if (a_rd_valid !== 1'b1 || a_rd_data !== 8'hFF || a_rd_err !== 1'b0) begin
         $display("FAIL inrange16: got v=%b d=%h e=%b want v=1 d=ff e=0", a_rd_valid, a_rd_data, a_rd_err);
      end else n_pass++;
      tick();
      n_checks++;
      if (b_rd_valid !== 1'b1 || b_rd_data !== 8'h22 || b_rd_err !== 1'b0) begin
         $display("FAIL last12: got v=%b d=%h e=%b want v=1 d=22 e=0", b_rd_valid, b_rd_data, b_rd_err);
      end else n_pass++;
      tick();
      n_checks++;
      if (b_rd_valid !== 1'b0 || b_rd_err !== 1'b0 || b_rd_data !== 8'h22) begin
         $display("FAIL after12: got v=%b e=%b d=%h want v=0 e=0 d=22", b_rd_valid, b_rd_err, b_rd_data);
      end else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      int stray;
      int rise;
      rd_en = 1'b1; rd_addr = 4'd3;
      tick();
      rd_addr = 4'd4;
      rst_n   = 1'b0;
      tick();
      idle_inputs();
      rst_n = 1'b1;
      n_checks++;
      if (a_init_done !== 1'b0 || a_rd_valid !== 1'b0) begin
         $display("FAIL midrst_drop: got done=%b v=%b want 0 0", a_init_done, a_rd_valid);
      end else n_pass++;
      stray = 0;
      rise  = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (a_rd_valid === 1'b1 || b_rd_valid === 1'b1) stray++;
         if (rise == 0 && a_init_done === 1'b1) rise = i;
      end
      n_checks++;
      if (stray != 0) $display("FAIL midrst_stray: got %0d valid pulses want 0", stray);
      else n_pass++;
      n_checks++;
      if (rise != 16) $display("FAIL midrst_init: init_done rose after %0d cycles want 16", rise);
      else n_pass++;
      rd_en = 1'b1; rd_addr = 4'd3;
      tick();
      idle_inputs();
      tick();
      n_checks++;
      if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h00) begin
         $display("FAIL midrst_cleared: got v=%b d=%h want v=1 d=00", a_rd_valid, a_rd_data);
      end else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      idle_inputs();
      test_reset();
      test_idle_read();
      test_write_read();
      test_collision();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
